// File: rtl/pc_sequencer_if.sv
// Handshake/bus bundle between the PC sequencer and the fetch/decode logic.
// The slave modport is the sequencer's view; master is the driver's view.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pc_at;
  logic [WIDTH-1:0] pc_prox;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             halt_req;
  logic             resume;
  logic             io_req;
  logic             io_ack;
  logic [WIDTH-1:0] pc_next;
  logic             pc_reset;
  logic             jump_stop;
  logic             halt;
  logic             flush;
  logic             fault;
  logic [1:0]       state;

  modport slave (
    input  pc_at, pc_prox, jump, jump_target, branch_taken, branch_target,
           halt_req, resume, io_req, io_ack,
    output pc_next, pc_reset, jump_stop, halt, flush, fault, state
  );

  modport master (
    output pc_at, pc_prox, jump, jump_target, branch_taken, branch_target,
           halt_req, resume, io_req, io_ack,
    input  pc_next, pc_reset, jump_stop, halt, flush, fault, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection FSM: boot, run, wait-for-I/O with timeout, halt.
// Only state, timeout counter and sticky fault are registered; outputs are decoded.
module pc_sequencer #(
  parameter int WIDTH      = 32,
  parameter int IO_TIMEOUT = 255
) (
  input logic             clock,
  input logic             reset,
  pc_sequencer_if.slave   bus
);
  localparam int CW = (IO_TIMEOUT < 1) ? 1 : $clog2(IO_TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(IO_TIMEOUT);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    WAIT_IO = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_fault, w_fault_nxt;
  logic [WIDTH-1:0] w_pc_next;
  logic            w_pc_reset, w_jump_stop, w_halt, w_flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= BOOT;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fault_nxt = r_fault;
    w_pc_next   = bus.pc_prox;
    w_pc_reset  = 1'b0;
    w_jump_stop = 1'b0;
    w_halt      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      BOOT: begin
        w_pc_reset  = 1'b1;
        w_flush     = 1'b1;
        w_pc_next   = '0;
        w_state_nxt = RUN;
      end
      RUN: begin
        if (bus.halt_req) begin
          w_pc_next   = bus.pc_at;
          w_halt      = 1'b1;
          w_state_nxt = HALT;
        end else if (bus.jump) begin
          w_pc_next = bus.jump_target;
          w_flush   = 1'b1;
        end else if (bus.branch_taken) begin
          w_pc_next = bus.branch_target;
          w_flush   = 1'b1;
        end else if (bus.io_req && !bus.io_ack) begin
          // Same-cycle ack means the data is already here: just advance.
          w_pc_next   = bus.pc_at;
          w_jump_stop = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_IO;
        end
      end
      WAIT_IO: begin
        if (bus.io_ack) begin
          w_state_nxt = RUN;
        end else begin
          w_pc_next   = bus.pc_at;
          w_jump_stop = 1'b1;
          if (r_cnt == TO) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = HALT;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      HALT: begin
        w_pc_next = bus.pc_at;
        w_halt    = 1'b1;
        if (bus.resume) w_state_nxt = RUN;
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  assign bus.pc_next   = w_pc_next;
  assign bus.pc_reset  = w_pc_reset;
  assign bus.jump_stop = w_jump_stop;
  assign bus.halt      = w_halt;
  assign bus.flush     = w_flush;
  assign bus.fault     = r_fault;
  assign bus.state     = r_state;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: directed vector table, multi-cycle I/O/halt/reset sequences,
// and randomized traffic compared with a behavioural model of the sequencer.
module tb_pc_sequencer;
  localparam int W  = 32;
  localparam int TO = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pc_sequencer_if #(.WIDTH(W)) b ();
  pc_sequencer #(.WIDTH(W), .IO_TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: mode 0 boot, 1 run, 2 waiting for I/O, 3 halted.
  int m_mode  = 0;
  int m_waits = 0;
  bit m_fault = 0;

  typedef struct {
    logic        jmp;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        hreq, res, ioreq, ioack;
    logic [31:0] pa, pp;
    logic [31:0] e_pc;
    logic [6:0]  e_fl;  // {pc_reset, jump_stop, halt, flush, fault, state}
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] flags_now();
    return {b.pc_reset, b.jump_stop, b.halt, b.flush, b.fault, b.state};
  endfunction

  task automatic drive(input logic rst, input logic jmp, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt, input logic hr,
                       input logic rs, input logic iq, input logic ia,
                       input logic [31:0] pa, input logic [31:0] pp);
    reset = rst; b.jump = jmp; b.jump_target = jt; b.branch_taken = br;
    b.branch_target = bt; b.halt_req = hr; b.resume = rs; b.io_req = iq;
    b.io_ack = ia; b.pc_at = pa; b.pc_prox = pp;
  endtask

  // Expected combinational outputs for the current model mode and bench inputs.
  task automatic model_out(output logic [31:0] epc, output logic [6:0] efl);
    bit pr = 0, js = 0, h = 0, fl = 0;
    epc = b.pc_prox;
    if (m_mode == 0) begin
      pr = 1; fl = 1; epc = 0;
    end else if (m_mode == 1) begin
      if (b.halt_req)          begin h = 1; epc = b.pc_at; end
      else if (b.jump)         begin fl = 1; epc = b.jump_target; end
      else if (b.branch_taken) begin fl = 1; epc = b.branch_target; end
      else if (b.io_req && !b.io_ack) begin js = 1; epc = b.pc_at; end
    end else if (m_mode == 2) begin
      if (!b.io_ack) begin js = 1; epc = b.pc_at; end
    end else begin
      h = 1; epc = b.pc_at;
    end
    efl = {pr, js, h, fl, m_fault, 2'(m_mode)};
  endtask

  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_waits = 0; m_fault = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (b.halt_req) m_mode = 3;
      else if (!b.jump && !b.branch_taken && b.io_req && !b.io_ack) begin
        m_mode = 2; m_waits = 0;
      end
    end else if (m_mode == 2) begin
      if (b.io_ack) m_mode = 1;
      else if (m_waits == TO) begin m_fault = 1; m_mode = 3; end
      else m_waits++;
    end else if (b.resume) begin
      m_mode = 1;
    end
  endtask

  task automatic settle_chk(input string tag);
    logic [31:0] epc;
    logic [6:0]  efl;
    @(negedge clock);
    model_out(epc, efl);
    check({tag, " pc_next"}, b.pc_next, epc);
    check({tag, " flags"}, 32'(flags_now()), 32'(efl));
  endtask

  task automatic adv();
    @(posedge clock);
    model_step();
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clock); model_step(); #1;

    // jmp  jt     br  bt     hr rs iq ia pa            pp     e_pc   e_fl
    tbl.push_back('{0, 0,     0, 0,     0, 0, 0, 0, 32'h0,    32'h1,  32'h0,  7'b1001_0_00});
    tbl.push_back('{0, 0,     0, 0,     0, 0, 0, 0, 32'h0,    32'h1,  32'h1,  7'b0000_0_01});
    tbl.push_back('{0, 0,     0, 0,     0, 0, 0, 0, 32'h1,    32'h2,  32'h2,  7'b0000_0_01});
    tbl.push_back('{0, 0,     0, 0,     0, 0, 0, 0, 32'h2,    32'h3,  32'h3,  7'b0000_0_01});
    tbl.push_back('{1, 32'h40, 1, 32'h80, 0, 0, 0, 0, 32'h3,  32'h4,  32'h40, 7'b0001_0_01});
    tbl.push_back('{0, 0,     0, 0,     0, 0, 0, 0, 32'h40,   32'h41, 32'h41, 7'b0000_0_01});
    tbl.push_back('{0, 0,     1, 32'h80, 0, 0, 0, 0, 32'h41,  32'h42, 32'h80, 7'b0001_0_01});
    tbl.push_back('{1, 32'h40, 0, 0,    1, 0, 0, 0, 32'h80,   32'h81, 32'h80, 7'b0010_0_01});
    tbl.push_back('{1, 32'h40, 0, 0,    0, 0, 1, 0, 32'h80,   32'h81, 32'h80, 7'b0010_0_11});
    tbl.push_back('{0, 0,     0, 0,     0, 1, 0, 0, 32'h80,   32'h81, 32'h80, 7'b0010_0_11});
    tbl.push_back('{0, 0,     0, 0,     0, 0, 0, 0, 32'h80,   32'h81, 32'h81, 7'b0000_0_01});
    tbl.push_back('{0, 0,     0, 0,     0, 0, 1, 1, 32'h5,    32'h6,  32'h6,  7'b0000_0_01});
    tbl.push_back('{0, 0,     0, 0,     0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 7'b0000_0_01});

    foreach (tbl[i]) begin
      drive(0, tbl[i].jmp, tbl[i].jt, tbl[i].br, tbl[i].bt, tbl[i].hreq,
            tbl[i].res, tbl[i].ioreq, tbl[i].ioack, tbl[i].pa, tbl[i].pp);
      @(negedge clock);
      check($sformatf("vec%0d pc_next", i), b.pc_next, tbl[i].e_pc);
      check($sformatf("vec%0d flags", i), 32'(flags_now()), 32'(tbl[i].e_fl));
      adv();
    end

    // I/O request at pc 5, acknowledged after three waiting cycles.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 6);
    settle_chk("io_enter");
    check("io_enter jump_stop", 32'(b.jump_stop), 1);
    check("io_enter pc", b.pc_next, 5);
    adv();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 6);
      settle_chk("io_wait");
      check("io_wait state", 32'(b.state), 2);
      check("io_wait pc", b.pc_next, 5);
      adv();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 6);
    settle_chk("io_ack");
    check("io_ack pc", b.pc_next, 6);
    check("io_ack jump_stop", 32'(b.jump_stop), 0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 7);
    settle_chk("io_done");
    check("io_done state", 32'(b.state), 1);
    adv();

    // Timeout: five unanswered waiting cycles, then HALT with sticky fault.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 10);
    settle_chk("to_enter");
    adv();
    for (int k = 0; k < TO + 1; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 10);
      settle_chk("to_wait");
      check("to_wait state", 32'(b.state), 2);
      check("to_wait fault", 32'(b.fault), 0);
      adv();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 9, 10);
    settle_chk("to_halt");
    check("to_halt state", 32'(b.state), 3);
    check("to_halt fault", 32'(b.fault), 1);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 10);
    settle_chk("to_resume");
    check("to_resume state", 32'(b.state), 1);
    check("to_resume fault", 32'(b.fault), 1);
    check("to_resume halt", 32'(b.halt), 0);
    adv();

    // Reset landing in the middle of an I/O wait.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 4);
    settle_chk("rw_enter");
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    settle_chk("rw_wait");
    adv();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    settle_chk("rw_rst");
    check("rw_rst state", 32'(b.state), 2);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    settle_chk("rw_boot");
    check("rw_boot state", 32'(b.state), 0);
    check("rw_boot fault", 32'(b.fault), 0);
    check("rw_boot pc_reset", 32'(b.pc_reset), 1);
    check("rw_boot pc", b.pc_next, 0);
    adv();

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pa;
      pa = $urandom;
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, $urandom,
            $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, pa,
            ($urandom_range(0, 3) == 0) ? $urandom : pa + 1);
      settle_chk("rnd");
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 32, PC width in bits.
REQ-002 SHALL have parameter: IO_TIMEOUT, 255, maximum cycles spent in WAIT_IO before a fault.
REQ-003 SHALL have port: clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports:
- pc_at  in  WIDTH  current PC.
- pc_prox  in  WIDTH  PC+1 from the PC register.
REQ-006 SHALL have ports:
- jump  in  1  unconditional jump request.
- jump_target  in  WIDTH  target for jump.
REQ-007 SHALL have ports:
- branch_taken  in  1  resolved taken branch.
- branch_target  in  WIDTH  target for branch_taken.
REQ-008 SHALL have ports:
- halt_req  in  1  halt instruction decoded.
- resume  in  1  leave HALT.
REQ-009 SHALL have ports:
- io_req  in  1  instruction needs external input.
- io_ack  in  1  input data valid.
REQ-010 SHALL have ports:
- pc_next  out  WIDTH  value driven to the PC register's pcIN.
- pc_reset  out  1  reset to the PC register.
- jump_stop  out  1  PC holds pcOUTat while pcOUTprox advances.
- halt  out  1  PC freezes completely.
REQ-011 SHALL have ports:
- flush  out  1  squash the instruction in decode.
- fault  out  1  sticky I/O timeout flag.
- state  out  2  encoded FSM state.

Function
REQ-012 SHALL implement FSM states BOOT=0, RUN=1, WAIT_IO=2, HALT=3; state register only, outputs decoded from state plus current inputs.
REQ-013 SHALL, in BOOT, drive pc_reset=1, halt=0, jump_stop=0, flush=1, pc_next=0, and go to RUN next cycle unconditionally.
REQ-014 SHALL, in RUN, select pc_next by fixed priority:
- halt_req -> pc_at
- jump -> jump_target
- branch_taken -> branch_target
- io_req -> pc_at
- otherwise -> pc_prox
REQ-015 SHALL, in RUN with halt_req=1, assert halt and go to HALT; jump, branch and io_req in the same cycle are ignored.
REQ-016 SHALL, in RUN with jump or branch_taken (no halt_req), assert flush=1 for that cycle and remain in RUN.
REQ-017 SHALL, in RUN with io_req=1 and no higher-priority event, assert jump_stop=1, load the timeout counter with 0, and go to WAIT_IO.
- If io_ack=1 in that same cycle, SHALL instead stay in RUN with jump_stop=0 and pc_next=pc_prox.
REQ-018 SHALL, in WAIT_IO, drive jump_stop=1 and pc_next=pc_at, and increment the counter each cycle io_ack=0.
REQ-019 SHALL, in WAIT_IO with io_ack=1, drive jump_stop=0 and pc_next=pc_prox in that cycle and return to RUN next cycle.
REQ-020 SHALL, in WAIT_IO when the counter equals IO_TIMEOUT with io_ack=0, set fault=1 and go to HALT.
- io_ack=1 on the same cycle wins: no fault, return to RUN.
REQ-021 SHALL, in HALT, drive halt=1, jump_stop=0, flush=0, pc_next=pc_at; all inputs other than resume and reset are ignored.
REQ-022 SHALL, in HALT with resume=1, return to RUN with halt=0 in the following cycle.
- fault is not cleared by resume.
REQ-023 SHALL size the timeout counter to hold IO_TIMEOUT without wrap; it never exceeds IO_TIMEOUT.
REQ-024 SHALL treat pc_next as combinational; pc_prox wrap from all-ones to 0 is passed through unmodified.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, enter BOOT from any state, including WAIT_IO or HALT.
REQ-026 SHALL, on reset, clear fault and the counter.
REQ-027 SHALL, with reset=1 asserted, produce BOOT outputs on the next cycle: pc_reset=1, halt=0, jump_stop=0, flush=1, pc_next=0, state=0.

Verification
REQ-028 SHALL verify: reset one cycle, then idle -> state BOOT then RUN; pc_next follows pc_prox (1,2,3...).
REQ-029 SHALL verify: RUN, jump=1, jump_target=0x40, branch_taken=1, branch_target=0x80 -> pc_next=0x40, flush=1 for one cycle.
REQ-030 SHALL verify: io_req=1 at pc_at=5, io_ack after 3 cycles:
- state WAIT_IO for 3 cycles, jump_stop=1, pc_next=5.
- ack cycle gives pc_next=pc_prox, then RUN.
REQ-031 SHALL verify: io_req with no io_ack, IO_TIMEOUT=4:
- fault=1 and state HALT after 5 WAIT_IO cycles.
- resume returns to RUN with fault still 1.
REQ-032 SHALL verify: halt_req=1 with jump=1 in the same cycle -> HALT, pc_next=pc_at, jump ignored; resume -> RUN.
REQ-033 SHALL verify: reset asserted mid-WAIT_IO -> BOOT next cycle, fault=0, pc_reset=1.
